// File: rtl/rc4_stream_decrypt.sv
// RC4 stream cipher engine: S-box init, multi-byte key schedule, then PRGA
// with valid/ready handshakes on both sides (symmetric: also encrypts).
module rc4_stream_decrypt #(
    parameter int KEY_BYTES = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [KEY_BYTES*8-1:0] key,
    input  logic [4:0]             key_len,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [7:0]             out_data,
    input  logic                   out_ready,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        KSA,
        RUN
    } state_t;

    state_t state, state_nxt;

    logic [7:0]             sbox [256];
    logic [7:0]             i_q, j_q;
    logic [4:0]             k_q, len_q, len_eff;
    logic [KEY_BYTES*8-1:0] key_q;

    logic [7:0] key_byte, ksa_si, ksa_j;
    logic [7:0] i_nxt, j_nxt, prga_si, prga_sj, ks_idx, ks_byte;
    logic       fire;

    logic       we_a, we_b;
    logic [7:0] addr_a, addr_b, dat_a, dat_b;

    always_comb begin
        if (key_len == 5'd0)
            len_eff = 5'd1;
        else if (key_len > 5'(KEY_BYTES))
            len_eff = 5'(KEY_BYTES);
        else
            len_eff = key_len;
    end

    assign key_byte = key_q[8*k_q +: 8];
    assign ksa_si   = sbox[i_q];
    assign ksa_j    = j_q + ksa_si + key_byte;

    assign i_nxt   = i_q + 8'd1;
    assign prga_si = sbox[i_nxt];
    assign j_nxt   = j_q + prga_si;
    assign prga_sj = sbox[j_nxt];
    assign ks_idx  = prga_si + prga_sj;

    // Keystream lookup must see the swap that commits at this same edge.
    always_comb begin
        if (ks_idx == i_nxt)
            ks_byte = prga_sj;
        else if (ks_idx == j_nxt)
            ks_byte = prga_si;
        else
            ks_byte = sbox[ks_idx];
    end

    assign in_ready = (state == RUN) && (!out_valid || out_ready);
    assign fire     = in_valid && in_ready;
    assign busy     = (state == INIT) || (state == KSA);

    always_comb begin
        we_a   = 1'b0;
        we_b   = 1'b0;
        addr_a = 8'd0;
        addr_b = 8'd0;
        dat_a  = 8'd0;
        dat_b  = 8'd0;
        if (!reset && !start) begin
            unique case (state)
                INIT: begin
                    we_a   = 1'b1;
                    addr_a = i_q;
                    dat_a  = i_q;
                end
                KSA: begin
                    we_a   = 1'b1;
                    addr_a = i_q;
                    dat_a  = sbox[ksa_j];
                    we_b   = 1'b1;
                    addr_b = ksa_j;
                    dat_b  = ksa_si;
                end
                RUN: begin
                    if (fire) begin
                        we_a   = 1'b1;
                        addr_a = i_nxt;
                        dat_a  = prga_sj;
                        we_b   = 1'b1;
                        addr_b = j_nxt;
                        dat_b  = prga_si;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (we_a)
            sbox[addr_a] <= dat_a;
        if (we_b)
            sbox[addr_b] <= dat_b;
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = INIT;
        end else begin
            unique case (state)
                INIT:    if (i_q == 8'hFF) state_nxt = KSA;
                KSA:     if (i_q == 8'hFF) state_nxt = RUN;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            i_q       <= 8'd0;
            j_q       <= 8'd0;
            k_q       <= 5'd0;
            len_q     <= 5'd1;
            key_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
        end else if (start) begin
            i_q       <= 8'd0;
            j_q       <= 8'd0;
            k_q       <= 5'd0;
            len_q     <= len_eff;
            key_q     <= key;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                INIT: begin
                    i_q <= i_q + 8'd1;
                end
                KSA: begin
                    i_q <= i_q + 8'd1;
                    j_q <= (i_q == 8'hFF) ? 8'd0 : ksa_j;
                    k_q <= (k_q == len_q - 5'd1) ? 5'd0 : k_q + 5'd1;
                end
                RUN: begin
                    if (fire) begin
                        i_q       <= i_nxt;
                        j_q       <= j_nxt;
                        out_data  <= in_data ^ ks_byte;
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
